// File: rtl/pc_sequencer.sv
// pc_sequencer: instruction-cycle controller for the 8-bit simple processor.
//
// It steps through FETCH/DECODE/EXEC. It drives program_counter through its
// pc_inc/load/pc_in controls and handshakes with instruction memory
// (mem_rd/mem_ready/mem_data). It latches the instruction register, issues
// the ALU execute strobe and counts retired instructions. Two-byte JMP/JZ
// instructions read their target byte in the OPER state.
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   run             start request, looked at only in IDLE
//   mem_ready       memory read completes this cycle
//   mem_data        instruction/operand byte (valid with mem_ready)
//   zero            ALU zero flag, sampled by JZ when its operand arrives
//   mem_rd          memory read request (FETCH/OPER only)
//   pc_inc, load    program_counter controls, never both high
//   pc_in           jump target, forced to zero unless load is high
//   ir_out          instruction register
//   alu_en          one-cycle ALU execute strobe
//   illegal         one-cycle pulse on an undefined opcode
//   halted          high while halted (exited only by rst)
//   instr_count     retired-instruction counter, wraps modulo 256
module pc_sequencer #(
   parameter int OP_W   = 3,
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_data,
   input  logic              zero,
   output logic              mem_rd,
   output logic              pc_inc,
   output logic              load,
   output logic [DATA_W-1:0] pc_in,
   output logic [DATA_W-1:0] ir_out,
   output logic              alu_en,
   output logic              illegal,
   output logic              halted,
   output logic [7:0]        instr_count
);

   localparam logic [OP_W-1:0] OP_NOP = OP_W'(3'b000);
   localparam logic [OP_W-1:0] OP_ALU = OP_W'(3'b001);
   localparam logic [OP_W-1:0] OP_JMP = OP_W'(3'b011);
   localparam logic [OP_W-1:0] OP_JZ  = OP_W'(3'b100);
   localparam logic [OP_W-1:0] OP_HLT = OP_W'(3'b111);

   typedef enum logic [2:0] {
      S_IDLE,
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_OPER,
      S_HALT
   } state_t;

   state_t              state_q, state_d;
   logic [DATA_W-1:0]   ir_q, ir_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                halted_q, halted_d;
   logic [OP_W-1:0]     opcode;

   assign opcode = ir_q[DATA_W-1 -: OP_W];

   always_comb begin
      state_d = state_q;
      ir_d    = ir_q;
      cnt_d   = cnt_q;
      mem_rd  = 1'b0;
      pc_inc  = 1'b0;
      load    = 1'b0;
      pc_in   = '0;
      alu_en  = 1'b0;
      illegal = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (run) state_d = S_FETCH;
         end
         S_FETCH: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               ir_d    = mem_data;
               pc_inc  = 1'b1;
               state_d = S_DECODE;
            end
         end
         S_DECODE: begin
            case (opcode)
               OP_NOP: begin
                  cnt_d   = cnt_q + 8'd1;
                  state_d = S_FETCH;
               end
               OP_ALU:        state_d = S_EXEC;
               OP_JMP, OP_JZ: state_d = S_OPER;
               OP_HLT: begin
                  cnt_d   = cnt_q + 8'd1;
                  state_d = S_HALT;
               end
               default: begin
                  // Undefined opcodes retire as NOPs but are flagged.
                  illegal = 1'b1;
                  cnt_d   = cnt_q + 8'd1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_EXEC: begin
            alu_en  = 1'b1;
            cnt_d   = cnt_q + 8'd1;
            state_d = S_FETCH;
         end
         S_OPER: begin
            mem_rd = 1'b1;
            if (mem_ready) begin
               // Only JMP/JZ reach OPER. The flag is taken with the operand byte.
               if (opcode == OP_JMP || zero) begin
                  load  = 1'b1;
                  pc_in = mem_data;
               end else begin
                  // Untaken JZ steps the PC over its operand byte.
                  pc_inc = 1'b1;
               end
               cnt_d   = cnt_q + 8'd1;
               state_d = S_FETCH;
            end
         end
         S_HALT: state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase

      // The PC and ALU must not move in a cycle that is being reset.
      if (rst) begin
         pc_inc  = 1'b0;
         load    = 1'b0;
         pc_in   = '0;
         alu_en  = 1'b0;
         illegal = 1'b0;
      end
   end

   assign halted_d = (state_d == S_HALT);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= S_IDLE;
         ir_q     <= '0;
         cnt_q    <= 8'd0;
         halted_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         ir_q     <= ir_d;
         cnt_q    <= cnt_d;
         halted_q <= halted_d;
      end
   end

   assign ir_out      = ir_q;
   assign halted      = halted_q;
   assign instr_count = cnt_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// tb_pc_sequencer: directed bench for pc_sequencer. It contains a small
// instruction memory and a program_counter model driven by the DUT's
// pc_inc/load/pc_in outputs.
module tb_pc_sequencer;

   logic       clk = 1'b0;
   logic       rst;
   logic       run;
   logic       mem_ready;
   logic [7:0] mem_data;
   logic       zero;
   logic       mem_rd, pc_inc, load, alu_en, illegal, halted;
   logic [7:0] pc_in, ir_out, instr_count;

   logic [7:0] mem [256];
   logic [7:0] pc;
   logic       pc_clr;

   int errors = 0;
   int checks = 0;

   logic [31:0] pcinc_m, load_m, alu_m, mrd_m, ill_m;
   logic [7:0]  pcin_at [32];
   logic [7:0]  pc_at [32];
   int          inv_bad;

   pc_sequencer #(.OP_W(3), .DATA_W(8)) dut (
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .mem_ready   (mem_ready),
      .mem_data    (mem_data),
      .zero        (zero),
      .mem_rd      (mem_rd),
      .pc_inc      (pc_inc),
      .load        (load),
      .pc_in       (pc_in),
      .ir_out      (ir_out),
      .alu_en      (alu_en),
      .illegal     (illegal),
      .halted      (halted),
      .instr_count (instr_count)
   );

   always #5 clk = ~clk;

   // program_counter model: increment has priority only for safety; the
   // DUT must never raise both.
   always @(posedge clk) begin
      if (pc_clr)      pc <= 8'd0;
      else if (pc_inc) pc <= pc + 8'd1;
      else if (load)   pc <= pc_in;
   end

   assign mem_data = mem[pc];

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 256; i++) mem[i] = 8'h00;
   endtask

   task automatic do_reset();
      rst = 1'b1; pc_clr = 1'b1; run = 1'b0; mem_ready = 1'b1; zero = 1'b0;
      tick();
      tick();
      rst = 1'b0; pc_clr = 1'b0;
   endtask

   // Pulse run from IDLE, then record n cycles (cycle 1 = first FETCH).
   // rdy/zm give mem_ready/zero per cycle, indexed by cycle number.
   task automatic run_prog(input int n, input logic [31:0] rdy, input logic [31:0] zm);
      pcinc_m = '0; load_m = '0; alu_m = '0; mrd_m = '0; ill_m = '0;
      inv_bad = 0;
      mem_ready = 1'b1;
      run = 1'b1;
      tick();
      run = 1'b0;
      for (int k = 1; k <= n; k++) begin
         mem_ready = rdy[k];
         zero      = zm[k];
         #1;
         pcinc_m[k] = pc_inc;
         load_m[k]  = load;
         alu_m[k]   = alu_en;
         mrd_m[k]   = mem_rd;
         ill_m[k]   = illegal;
         pcin_at[k] = pc_in;
         pc_at[k]   = pc;
         if (pc_inc && load) inv_bad++;
         if (!load && pc_in != 8'h00) inv_bad++;
         tick();
      end
      mem_ready = 1'b1;
      zero      = 1'b0;
   endtask

   initial begin
      int mrd_seen;
      rst = 1'b1; pc_clr = 1'b1; run = 1'b0; mem_ready = 1'b0; zero = 1'b0;
      clear_mem();

      // Reset and idle
      do_reset();
      mrd_seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (mem_rd || pc_inc || load || alu_en) mrd_seen++;
         tick();
      end
      check_val("idle_strobes", mrd_seen, 0);
      check_val("rst_ir", ir_out, 8'h00);
      check_val("rst_pc_in", pc_in, 8'h00);
      check_val("rst_halted", halted, 1'b0);
      check_val("rst_count", instr_count, 8'd0);
      check_val("rst_illegal", illegal, 1'b0);

      // Linear program: NOP, ALU, HLT
      do_reset(); clear_mem();
      mem[0] = 8'h00; mem[1] = 8'h20; mem[2] = 8'he0;
      run_prog(8, '1, '0);
      check_val("lin_pcinc", pcinc_m, 32'h4a);
      check_val("lin_mrd", mrd_m, 32'h4a);
      check_val("lin_alu", alu_m, 32'h20);
      check_val("lin_inv", inv_bad, 0);
      check_val("lin_halted", halted, 1'b1);
      check_val("lin_pc", pc, 8'h03);
      check_val("lin_count", instr_count, 8'd3);
      run = 1'b1;
      tick(); tick();
      run = 1'b0;
      check_val("halt_sticky", halted, 1'b1);
      check_val("halt_no_rd", mem_rd, 1'b0);

      // JMP 0x40
      do_reset(); clear_mem();
      mem[0] = 8'h60; mem[1] = 8'h40; mem[8'h40] = 8'he0;
      run_prog(6, '1, '0);
      check_val("jmp_load", load_m, 32'h08);
      check_val("jmp_pc_in", pcin_at[3], 8'h40);
      check_val("jmp_pcinc", pcinc_m, 32'h12);
      check_val("jmp_fetch_addr", pc_at[4], 8'h40);
      check_val("jmp_inv", inv_bad, 0);
      check_val("jmp_halted", halted, 1'b1);
      check_val("jmp_count", instr_count, 8'd2);

      // JZ not taken: zero high at fetch/decode, low when the operand arrives
      do_reset(); clear_mem();
      mem[0] = 8'h80; mem[1] = 8'h10; mem[2] = 8'he0; mem[8'h10] = 8'he0;
      run_prog(6, '1, 32'h6);
      check_val("jz0_load", load_m, 32'h0);
      check_val("jz0_pcinc", pcinc_m, 32'h1a);
      check_val("jz0_fetch_addr", pc_at[4], 8'h02);
      check_val("jz0_count", instr_count, 8'd2);

      // JZ taken
      do_reset();
      run_prog(6, '1, 32'h8);
      check_val("jz1_load", load_m, 32'h08);
      check_val("jz1_pc_in", pcin_at[3], 8'h10);
      check_val("jz1_fetch_addr", pc_at[4], 8'h10);
      check_val("jz1_inv", inv_bad, 0);
      check_val("jz1_halted", halted, 1'b1);

      // Wait states in FETCH
      do_reset(); clear_mem();
      run_prog(4, ~32'h0e, '0);
      check_val("wait_mrd", mrd_m, 32'h1e);
      check_val("wait_pcinc", pcinc_m, 32'h10);
      check_val("wait_ir", ir_out, 8'h00);

      // rst during an OPER wait, with mem_ready high in the reset cycle
      do_reset(); clear_mem();
      mem[0] = 8'h60; mem[1] = 8'h40;
      run_prog(3, ~32'h08, '0);
      check_val("oper_wait_pc", pc, 8'h01);
      rst = 1'b1; mem_ready = 1'b1;
      #1;
      check_val("rstcyc_load", load, 1'b0);
      check_val("rstcyc_pcinc", pc_inc, 1'b0);
      tick();
      rst = 1'b0;
      #1;
      check_val("rst_oper_pc", pc, 8'h01);
      check_val("rst_oper_ir", ir_out, 8'h00);
      check_val("rst_oper_count", instr_count, 8'd0);
      tick();
      check_val("rst_oper_idle", mem_rd, 1'b0);

      // Undefined opcode 0x40 then HLT
      do_reset(); clear_mem();
      mem[0] = 8'h40; mem[1] = 8'he0;
      run_prog(5, '1, '0);
      check_val("undef_illegal", ill_m, 32'h04);
      check_val("undef_halted", halted, 1'b1);
      check_val("undef_count", instr_count, 8'd2);

      // 256 NOPs: counter wraps
      do_reset(); clear_mem();
      run = 1'b1;
      tick();
      run = 1'b0;
      for (int i = 0; i < 510; i++) tick();
      check_val("wrap_255", instr_count, 8'd255);
      tick(); tick();
      check_val("wrap_0", instr_count, 8'd0);
      check_val("wrap_not_halted", halted, 1'b0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
